fifo_multi: RTL and testbench

FIFO_MULTI -- requirements
Module: fifo_multi

---
 rtl/fifo_multi.sv | 83 ++++++++
 tb/tb_fifo_multi.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_multi.sv
// Multi-lane FIFO: up to IN_W packed enqueues and OUT_W in-order dequeues per cycle.
// Status and read ports come from registered pointers only; no write-to-read bypass.
module fifo_multi #(
    parameter int WIDTH     = 32,
    parameter int NUM       = 8,
    parameter int IN_W      = 2,
    parameter int OUT_W     = 2,
    parameter int AF_THRESH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             IN_flush,
    input  logic [IN_W-1:0]                  IN_valid,
    input  logic [IN_W-1:0][WIDTH-1:0]       IN_data,
    output logic                             OUT_ready,
    output logic [OUT_W-1:0]                 OUT_valid,
    output logic [OUT_W-1:0][WIDTH-1:0]      OUT_data,
    input  logic [$clog2(OUT_W):0]           IN_deq,
    output logic [$clog2(NUM):0]             OUT_count,
    output logic [$clog2(NUM):0]             OUT_free,
    output logic                             OUT_almostFull
);

    localparam int AW = $clog2(NUM);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [NUM];
    logic [WIDTH-1:0] mem_d [NUM];
    logic [PW-1:0]    count;
    logic [PW-1:0]    wr_off;
    logic             accept;

    // Handshake: OUT_ready depends only on registered occupancy; when it is high
    // every set IN_valid lane is taken at the edge, otherwise the producer holds.
    // OUT_valid is a prefix mask; the consumer takes IN_deq of those lanes.
    always_comb begin
        count          = wr_q - rd_q;
        OUT_count      = count;
        OUT_free       = PW'(NUM) - count;
        OUT_ready      = 32'(OUT_free) >= 32'(IN_W);
        OUT_almostFull = 32'(OUT_free) <= 32'(AF_THRESH);
        for (int i = 0; i < OUT_W; i++) begin
            OUT_valid[i] = 32'(count) > 32'(i);
            OUT_data[i]  = mem_q[AW'(rd_q + PW'(i))];
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wr_off = '0;
        accept = OUT_ready && !IN_flush;
        // Valid lanes pack into consecutive slots; index truncation wraps modulo NUM.
        for (int i = 0; i < IN_W; i++) begin
            if (accept && IN_valid[i]) begin
                mem_d[AW'(wr_q + wr_off)] = IN_data[i];
                wr_off = wr_off + PW'(1);
            end
        end
        wr_d = IN_flush ? '0 : wr_q + wr_off;
        rd_d = IN_flush ? '0 : rd_q + PW'(IN_deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Taking more entries than are presented is a consumer error.
    deq_legal_a: assert property (@(posedge clk) disable iff (rst)
        32'(IN_deq) <= ((32'(count) < 32'(OUT_W)) ? 32'(count) : 32'(OUT_W)));

endmodule

// File: tb/tb_fifo_multi.sv
// Directed bench for fifo_multi: driver pushes expected entries into exp_q,
// a negedge monitor pops and compares them against the dequeued lanes.
module tb_fifo_multi;

    localparam int WIDTH = 32;
    localparam int NUM   = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  IN_flush;
    logic [1:0]            IN_valid;
    logic [1:0][WIDTH-1:0] IN_data;
    logic                  OUT_ready;
    logic [1:0]            OUT_valid;
    logic [1:0][WIDTH-1:0] OUT_data;
    logic [1:0]            IN_deq;
    logic [3:0]            OUT_count;
    logic [3:0]            OUT_free;
    logic                  OUT_almostFull;

    int                    n_vec = 0;
    int                    n_bad = 0;
    int                    model_cnt = 0;
    logic [WIDTH-1:0]      exp_q [$];

    fifo_multi dut (
        .clk(clk), .rst(rst), .IN_flush(IN_flush), .IN_valid(IN_valid),
        .IN_data(IN_data), .OUT_ready(OUT_ready), .OUT_valid(OUT_valid),
        .OUT_data(OUT_data), .IN_deq(IN_deq), .OUT_count(OUT_count),
        .OUT_free(OUT_free), .OUT_almostFull(OUT_almostFull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int fr;
        logic [31:0] mask;
        fr   = NUM - model_cnt;
        mask = (model_cnt >= 2) ? 32'd3 : (model_cnt == 1) ? 32'd1 : 32'd0;
        chk({tag, "/count"}, 32'(OUT_count), 32'(model_cnt));
        chk({tag, "/free"},  32'(OUT_free),  32'(fr));
        chk({tag, "/ready"}, 32'(OUT_ready), (fr >= 2) ? 32'd1 : 32'd0);
        chk({tag, "/afull"}, 32'(OUT_almostFull), (fr <= 2) ? 32'd1 : 32'd0);
        chk({tag, "/valid"}, 32'(OUT_valid), mask);
    endtask

    // Checks state left by the previous edge, then drives the next cycle's inputs.
    task automatic step(input string tag, input logic [1:0] v, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] deq, input logic fl);
        @(posedge clk);
        #1;
        check_status(tag);
        IN_valid   = v;
        IN_data[0] = d0;
        IN_data[1] = d1;
        IN_deq     = deq;
        IN_flush   = fl;
        if (fl) begin
            model_cnt = 0;
        end else begin
            if (NUM - model_cnt >= 2) begin
                if (v[0]) begin exp_q.push_back(d0); model_cnt++; end
                if (v[1]) begin exp_q.push_back(d1); model_cnt++; end
            end
            model_cnt -= int'(deq);
        end
    endtask

    task automatic idle(input string tag, input logic [1:0] deq);
        step(tag, 2'b00, 32'h0, 32'h0, deq, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (IN_flush) begin
                    exp_q.delete();
                end else begin
                    for (int i = 0; i < int'(IN_deq); i++) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL deq_underflow: lane %0d taken with no expected entry", i);
                        end else begin
                            chk($sformatf("data_lane%0d", i), OUT_data[i], exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        IN_flush = 1'b0;
        IN_valid = 2'b00;
        IN_data  = '0;
        IN_deq   = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        step("enq_ab", 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 2'd0, 1'b0);
        idle("deq_ab", 2'd2);
        step("flush0", 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
        step("enq_mask10", 2'b10, 32'hDEAD_0000, 32'h0000_00C5, 2'd0, 1'b0);
        idle("deq_y", 2'd1);

        step("fill1", 2'b11, 32'hC000_0000, 32'hC000_0001, 2'd0, 1'b0);
        step("fill2", 2'b11, 32'hC000_0002, 32'hC000_0003, 2'd0, 1'b0);
        step("fill3", 2'b11, 32'hC000_0004, 32'hC000_0005, 2'd0, 1'b0);
        step("fill4", 2'b01, 32'hC000_0006, 32'hBAD0_0000, 2'd0, 1'b0);
        step("full_drop", 2'b11, 32'hD000_0000, 32'hD000_0001, 2'd2, 1'b0);
        idle("after_drop", 2'd2);
        idle("drain2", 2'd2);
        idle("drain3", 2'd1);

        step("flush1", 2'b00, 32'h0, 32'h0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("wfill", 2'b11, 32'h5100 + 32'(2*i), 32'h5101 + 32'(2*i), 2'd0, 1'b0);
        step("wfill4", 2'b01, 32'h5106, 32'h0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            idle("wdrain", 2'd2);
        idle("wdrain4", 2'd1);
        step("enq_pq", 2'b11, 32'h0000_00AF, 32'h0000_00BF, 2'd0, 1'b0);
        idle("deq_p", 2'd1);
        idle("deq_q", 2'd1);

        step("f4a", 2'b11, 32'hF000_0000, 32'hF000_0001, 2'd0, 1'b0);
        step("f4b", 2'b11, 32'hF000_0002, 32'hF000_0003, 2'd0, 1'b0);
        step("flush4", 2'b11, 32'hF000_0004, 32'hF000_0005, 2'd1, 1'b1);
        idle("post_flush", 2'd0);

        step("sim1", 2'b11, 32'hE000_0000, 32'hE000_0001, 2'd0, 1'b0);
        step("sim2", 2'b11, 32'hE000_0002, 32'hE000_0003, 2'd1, 1'b0);
        @(posedge clk);
        #1;
        check_status("pre_rst");
        IN_valid = 2'b00;
        IN_deq   = 2'd0;
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        model_cnt = 0;
        check_status("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;

        step("post_rst_enq", 2'b11, 32'h7000_0001, 32'h7000_0002, 2'd0, 1'b0);
        idle("post_rst_deq", 2'd2);
        idle("idle_end", 2'd0);
        @(posedge clk);
        #1;
        check_status("final");
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
